// File: rtl/xnor2_serial_cmp_ctrl_if.sv
// rtl/xnor2_serial_cmp_ctrl_if.sv - operand/result and xnor2 cell bundle for the serial compare sequencer
interface xnor2_serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int IDXW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             xa1;
    logic             xa2;
    logic             xzn;
    logic             busy;
    logic             done;
    logic             eq;
    logic [IDXW-1:0]  mismatch_idx;

    modport master (
        output start, opa, opb, xzn,
        input  xa1, xa2, busy, done, eq, mismatch_idx
    );

    modport slave (
        input  start, opa, opb, xzn,
        output xa1, xa2, busy, done, eq, mismatch_idx
    );
endinterface

// File: rtl/xnor2_serial_cmp_ctrl.sv
// rtl/xnor2_serial_cmp_ctrl.sv - bit-serial equality compare driving one shared external xnor2 cell
module xnor2_serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rn,
    xnor2_serial_cmp_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;
    logic [IDXW-1:0]  cnt;
    logic [IDXW-1:0]  idx_acc;
    logic             eq_acc;
    logic             xa1_r;
    logic             xa2_r;
    logic             eq_r;
    logic [IDXW-1:0]  idx_r;
    logic             accept;
    logic             last;
    logic             eq_nxt;
    logic [IDXW-1:0]  idx_nxt;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                last = (cnt == IDXW'(WIDTH - 1));
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Only the first mismatch records its index; eq_acc falling blocks later ones.
    assign eq_nxt  = eq_acc & bus.xzn;
    assign idx_nxt = (eq_acc && !bus.xzn) ? cnt : idx_acc;

    // A1/A2 come straight from flops: bit 0 is loaded on acceptance, the rest
    // shift out of rega/regb, and the cell is parked at 0/0 after the last bit.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            rega    <= '0;
            regb    <= '0;
            cnt     <= '0;
            idx_acc <= '0;
            eq_acc  <= 1'b0;
            xa1_r   <= 1'b0;
            xa2_r   <= 1'b0;
            eq_r    <= 1'b0;
            idx_r   <= '0;
        end else if (accept) begin
            rega    <= bus.opa >> 1;
            regb    <= bus.opb >> 1;
            xa1_r   <= bus.opa[0];
            xa2_r   <= bus.opb[0];
            cnt     <= '0;
            idx_acc <= '0;
            eq_acc  <= 1'b1;
        end else if (state == S_RUN) begin
            rega    <= rega >> 1;
            regb    <= regb >> 1;
            cnt     <= cnt + IDXW'(1);
            eq_acc  <= eq_nxt;
            idx_acc <= idx_nxt;
            if (last) begin
                xa1_r <= 1'b0;
                xa2_r <= 1'b0;
                eq_r  <= eq_nxt;
                idx_r <= eq_nxt ? '0 : idx_nxt;
            end else begin
                xa1_r <= rega[0];
                xa2_r <= regb[0];
            end
        end
    end

    assign bus.xa1          = xa1_r;
    assign bus.xa2          = xa2_r;
    assign bus.busy         = (state == S_RUN);
    assign bus.done         = (state == S_DONE);
    assign bus.eq           = eq_r;
    assign bus.mismatch_idx = idx_r;
endmodule

// File: tb/tb_xnor2_serial_cmp_ctrl.sv
// tb/tb_xnor2_serial_cmp_ctrl.sv - randomized model-checked bench for xnor2_serial_cmp_ctrl
module tb_xnor2_serial_cmp_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rn;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    xnor2_serial_cmp_ctrl_if #(.WIDTH(W)) bus8 ();
    xnor2_serial_cmp_ctrl_if #(.WIDTH(2)) bus2 ();

    assign bus8.xzn = ~(bus8.xa1 ^ bus8.xa2);
    assign bus2.xzn = ~(bus2.xa1 ^ bus2.xa2);

    xnor2_serial_cmp_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rn(rn), .bus(bus8.slave));
    xnor2_serial_cmp_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rn(rn), .bus(bus2.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] first_diff(input logic [W-1:0] x);
        logic [2:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) if (x[i]) r = 3'(i);
        return r;
    endfunction

    // Model: k = -1 idle, 0..W-1 presenting bit k, W = result cycle.
    int         k = -1;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    logic       meq = 1'b0;
    logic [2:0] midx = '0;

    always @(posedge clk or negedge rn) begin
        if (!rn) begin
            k = -1; meq = 1'b0; midx = '0;
        end else if (k >= 0 && k < W) begin
            k++;
            if (k == W) begin
                meq  = (ma == mb);
                midx = first_diff(ma ^ mb);
            end
        end else if (bus8.start) begin
            k = 0; ma = bus8.opa; mb = bus8.opb;
        end else begin
            k = -1;
        end
    end

    always @(negedge clk) begin
        logic run;
        run = (k >= 0 && k < W);
        chk("busy", bus8.busy, run);
        chk("done", bus8.done, k == W);
        chk("xa1", bus8.xa1, run ? ma[k] : 1'b0);
        chk("xa2", bus8.xa2, run ? mb[k] : 1'b0);
        chk("eq", bus8.eq, meq);
        chk("idx", bus8.mismatch_idx, midx);
    end

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit tog,
                           output logic e, output logic [2:0] idx, output int cyc,
                           output logic [W-1:0] s1, output logic [W-1:0] s2);
        @(posedge clk); #2;
        bus8.start = 1'b1; bus8.opa = a; bus8.opb = b;
        @(posedge clk); #2;
        bus8.start = 1'b0;
        cyc = 0; s1 = '0; s2 = '0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus8.done) break;
            if (bus8.busy && cyc <= W) begin
                s1[cyc-1] = bus8.xa1;
                s2[cyc-1] = bus8.xa2;
            end
            if (tog && bus8.busy) begin
                bus8.opa = W'($urandom); bus8.opb = W'($urandom); bus8.start = 1'($urandom);
            end
        end
        bus8.start = 1'b0;
        if (!bus8.done) chk("done_timeout", 0, 1);
        e = bus8.eq; idx = bus8.mismatch_idx;
    endtask

    initial begin
        logic e;
        logic [2:0] idx;
        int cyc;
        logic [W-1:0] s1, s2, a;
        int r;

        bus8.start = 1'b0; bus8.opa = '0; bus8.opb = '0;
        bus2.start = 1'b0; bus2.opa = '0; bus2.opb = '0;
        rn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rn = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_eq", bus8.eq, 0);
        chk("rst_xa1", bus8.xa1, 0);

        run_cmp(8'hA5, 8'hA5, 0, e, idx, cyc, s1, s2);
        chk("a5_lat", cyc, 9);
        chk("a5_xa1_seq", s1, 8'hA5);
        chk("a5_xa2_seq", s2, 8'hA5);
        chk("a5_eq", e, 1);
        chk("a5_idx", idx, 0);

        run_cmp(8'hF0, 8'h70, 0, e, idx, cyc, s1, s2);
        chk("f0_eq", e, 0);
        chk("f0_idx", idx, 7);
        run_cmp(8'h0F, 8'hFF, 0, e, idx, cyc, s1, s2);
        chk("0f_eq", e, 0);
        chk("0f_idx", idx, 4);

        run_cmp(8'h33, 8'h33, 1, e, idx, cyc, s1, s2);
        chk("tog_eq", e, 1);
        run_cmp(8'h3C, 8'h1C, 1, e, idx, cyc, s1, s2);
        chk("tog_idx", idx, 5);

        // back-to-back with START held high
        @(posedge clk); #2;
        bus8.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus8.opa = 8'h5A + 8'(i);
            bus8.opb = (i % 2 == 0) ? bus8.opa : bus8.opa ^ 8'h04;
            repeat (9) @(posedge clk);
            #2;
            chk("b2b_done", bus8.done, 1);
            chk("b2b_eq", bus8.eq, (i % 2 == 0));
        end
        bus8.start = 1'b0;
        repeat (2) @(posedge clk);

        // abort mid-RUN
        run_cmp(8'h77, 8'h77, 0, e, idx, cyc, s1, s2);
        @(posedge clk); #2;
        bus8.start = 1'b1; bus8.opa = 8'h12; bus8.opb = 8'h34;
        @(posedge clk); #2;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rn = 1'b0;
        #1;
        chk("abort_busy", bus8.busy, 0);
        chk("abort_done", bus8.done, 0);
        chk("abort_eq", bus8.eq, 0);
        chk("abort_idx", bus8.mismatch_idx, 0);
        chk("abort_xa", {bus8.xa1, bus8.xa2}, 0);
        repeat (2) @(posedge clk);
        #3 rn = 1'b1;
        run_cmp(8'h00, 8'h00, 0, e, idx, cyc, s1, s2);
        chk("post_rst_eq", e, 1);

        // WIDTH=2 build
        @(posedge clk); #2;
        bus2.start = 1'b1; bus2.opa = 2'b01; bus2.opb = 2'b11;
        @(posedge clk); #2;
        bus2.start = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus2.done) break;
        end
        chk("w2_lat", cyc, 3);
        chk("w2_eq", bus2.eq, 0);
        chk("w2_idx", bus2.mismatch_idx, 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #2;
            bus8.start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            bus8.opa = a;
            r = $urandom_range(0, 2);
            bus8.opb = (r == 0) ? a : (r == 1) ? a ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
        end
        bus8.start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
